osbm_arb: RTL and testbench

- Output-side arbiter for one output port of the 4-way switch; one instance per output port.
- Collects the per-output request bit from every input buffer manager.
- Grants one input at a time with round-robin fairness and drives that input's ack (FIFO read enable) for the whole packet.
- Releases the grant after the TAIL flit is popped; also drives the output crossbar mux select.

---
 rtl/osbm_arb.sv | 132 +++++++++++++
 tb/tb_osbm_arb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/osbm_arb.sv
// Output-side round-robin arbiter: grants one input per packet, frames on TAIL, drives crossbar select.
// Optional stall timeout enabled by defining OSBM_ARB_TIMEOUT_EN.
module osbm_arb #(
  parameter int NIN  = 4,
  parameter int SELW = 2
`ifdef OSBM_ARB_TIMEOUT_EN
  ,
  parameter int TO_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NIN-1:0]    req,
  input  logic [NIN-1:0]    empty,
  input  logic [2*NIN-1:0]  cmd,
  output logic [NIN-1:0]    ack,
  output logic [SELW-1:0]   sel,
  output logic              busy,
  output logic              ovalid,
  output logic              timeout
);

  localparam logic [1:0] CMD_TAIL = 2'b11;

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state_q, state_d;
  logic [NIN-1:0]  gnt_q, gnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic [SELW-1:0] win;
  logic            win_vld;
  logic [1:0]      cmd_sel;
  logic            tail_acc;
  logic            force_rel;

  // Rotating priority scan starting at ptr_q; the first requester found wins.
  always_comb begin : pick
    logic [SELW-1:0] idx;
    win     = ptr_q;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < NIN; k++) begin
      idx = ptr_q + SELW'(k);
      if (!win_vld && req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    cmd_sel = 2'b00;
    for (int i = 0; i < NIN; i++) begin
      if (sel_q == SELW'(i)) cmd_sel = cmd[2*i +: 2];
    end
  end

  assign ack      = gnt_q & ~empty;
  assign ovalid   = |ack;
  assign busy     = (state_q == XFER);
  assign sel      = sel_q;
  assign tail_acc = ack[sel_q] && (cmd_sel == CMD_TAIL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = XFER;
          gnt_d   = NIN'(1) << win;
          sel_d   = win;
        end
      end
      XFER: begin
        // The input just served drops to lowest priority for the next search.
        if (tail_acc || force_rel) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + SELW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef OSBM_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q;

  // Counter measures consecutive stalled XFER cycles; any pop restarts it.
  always_comb begin
    cnt_d = '0;
    if (state_q == XFER && !ack[sel_q]) cnt_d = cnt_q + 8'd1;
  end

  assign force_rel = (state_q == XFER) && (cnt_q == 8'(TO_CYCLES));
  assign timeout   = timeout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= force_rel && !tail_acc;
    end
  end
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_osbm_arb.sv
// Scoreboard bench for osbm_arb: FIFO source models per input, expected flit grants queued and popped on ovalid.
module tb_osbm_arb;

  localparam int NIN = 4;
  localparam logic [1:0] C_HEAD = 2'b10;
  localparam logic [1:0] C_BODY = 2'b01;
  localparam logic [1:0] C_TAIL = 2'b11;

  logic           clk = 1'b0;
  logic           rst;
  logic [NIN-1:0] req, empty, ack;
  logic [2*NIN-1:0] cmd;
  logic [1:0]     sel;
  logic           busy, ovalid, timeout;

  osbm_arb #(
    .NIN(NIN),
    .SELW(2)
`ifdef OSBM_ARB_TIMEOUT_EN
    ,
    .TO_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .rst(rst), .req(req), .empty(empty), .cmd(cmd),
    .ack(ack), .sel(sel), .busy(busy), .ovalid(ovalid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct { int sel; int gap; } exp_t;
  exp_t sb[$];

  logic [1:0] flits [NIN][32];
  int rd [NIN];
  int wr [NIN];
  bit stall [NIN];
  bit pend [NIN];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NIN; i++) begin
      req[i]        = (rd[i] != wr[i]);
      empty[i]      = (rd[i] == wr[i]) || stall[i];
      cmd[2*i +: 2] = (rd[i] != wr[i]) ? flits[i][rd[i]] : 2'b00;
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NIN; i++) begin
      rd[i] = 0; wr[i] = 0; stall[i] = 0; pend[i] = 0;
    end
    sb.delete();
  endtask

  task automatic load_pkt(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      flits[i][wr[i]] = (k == n-1) ? C_TAIL : ((k == 0) ? C_HEAD : C_BODY);
      wr[i]++;
    end
  endtask

  task automatic expect_flit(input int s, input int gap);
    exp_t e;
    e.sel = s; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic mark();
    last_cyc = cyc;
  endtask

  task automatic sample();
    exp_t e;
    check("ack_onehot", 32'($onehot0(ack)), 32'd1);
    check("ovalid_or", 32'(ovalid), 32'(|ack));
    check("ack_in_idle", 32'(ovalid & ~busy), 32'd0);
`ifndef OSBM_ARB_TIMEOUT_EN
    check("timeout_off", 32'(timeout), 32'd0);
`endif
    if (ovalid) begin
      if (sb.size() == 0) begin
        check("sb_extra_flit", 32'(ack), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_sel", 32'(sel), 32'(e.sel));
        check("sb_ack", 32'(ack), 32'(4'b0001 << e.sel));
        if (e.gap != 0) check("sb_gap", 32'(cyc - last_cyc), 32'(e.gap));
        last_cyc = cyc;
      end
    end
    for (int i = 0; i < NIN; i++) pend[i] = ack[i];
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NIN; i++) begin
      if (pend[i] && rd[i] != wr[i]) rd[i]++;
      pend[i] = 0;
    end
    drive_inputs();
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < bound) begin
      step();
      n++;
    end
    check("drain_done", 32'((sb.size() == 0) && !busy), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_all();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovalid", 32'(ovalid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    int n;

    // Reset mid-packet, then re-grant from pointer 0
    do_reset();
    load_pkt(1, 4); drive_inputs(); mark();
    expect_flit(1, 1); expect_flit(1, 1);
    repeat (3) step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_ack", 32'(ack), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_sel", 32'(sel), 32'd0);
    check("async_rst_ovalid", 32'(ovalid), 32'd0);
    check("async_rst_sb", 32'(sb.size()), 32'd0);
    clear_all(); drive_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); cyc++; #1;
    load_pkt(1, 2); drive_inputs(); mark();
    expect_flit(1, 1); expect_flit(1, 1);
    drain(50);

    // Single requester: 4-flit packet on input 2, busy drops after TAIL edge
    load_pkt(2, 4); drive_inputs(); mark();
    for (int k = 0; k < 4; k++) expect_flit(2, 1);
    repeat (4) step();
    check("single_busy_hold", 32'(busy), 32'd1);
    step();
    check("single_busy_fall", 32'(busy), 32'd0);
    drain(50);

    // Pointer now at 3: inputs 0 and 3 with single-flit packets -> 3 first
    load_pkt(0, 1); load_pkt(3, 1); drive_inputs(); mark();
    expect_flit(3, 1); expect_flit(0, 2);
    drain(50);

    // Round robin with all four requesting
    do_reset();
    load_pkt(0, 2); load_pkt(0, 2);
    load_pkt(1, 2); load_pkt(2, 2); load_pkt(3, 2);
    drive_inputs(); mark();
    expect_flit(0, 1); expect_flit(0, 1);
    expect_flit(1, 2); expect_flit(1, 1);
    expect_flit(2, 2); expect_flit(2, 1);
    expect_flit(3, 2); expect_flit(3, 1);
    expect_flit(0, 2); expect_flit(0, 1);
    drain(100);

    // Empty stall mid-packet on input 1
    load_pkt(1, 4); drive_inputs(); mark();
    expect_flit(1, 1); expect_flit(1, 4); expect_flit(1, 1); expect_flit(1, 1);
    repeat (2) step();
    stall[1] = 1; drive_inputs();
    repeat (3) step();
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_sel", 32'(sel), 32'd1);
    check("stall_ack", 32'(ack), 32'd0);
    stall[1] = 0; drive_inputs();
    drain(50);

    // TAIL at head while FIFO reports empty is not accepted
    stall[2] = 1; load_pkt(2, 1); drive_inputs(); mark();
    repeat (4) step();
    check("tailmask_busy", 32'(busy), 32'd1);
    check("tailmask_sel", 32'(sel), 32'd2);
    check("tailmask_ack", 32'(ack), 32'd0);
    expect_flit(2, 0);
    stall[2] = 0; drive_inputs();
    drain(50);

`ifdef OSBM_ARB_TIMEOUT_EN
    // Forced release after a stalled grant; input 3 served next
    do_reset();
    stall[0] = 1; load_pkt(0, 2); load_pkt(3, 1); drive_inputs(); mark();
    seen = 0; n = 0;
    while (!seen && n < 30) begin
      step();
      n++;
      if (timeout) seen = 1;
    end
    check("to_pulse", 32'(seen), 32'd1);
    check("to_cycles", 32'(n), 32'd10);
    check("to_busy", 32'(busy), 32'd0);
    expect_flit(3, 0); expect_flit(0, 0); expect_flit(0, 0);
    stall[0] = 0; drive_inputs();
    step();
    check("to_one_cycle", 32'(timeout), 32'd0);
    drain(50);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
